shift_normalizer: RTL

Iterative left-normalizer for the 32-bit datapath. Accepts an operand, shifts it left one bit per cycle until its MSB is significant, and returns the normalized value with the shift count. The count is sized and encoded so that `Shifter` (`shiftop` SRL, or SRA for signed) with `shiftamt = out_shamt` reconstructs the operand. It feeds the multi-cycle execute path, with valid/ready on both sides.

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shift_normalizer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/shifter_pkg.sv
// Shared shifter definitions: shift-op encodings, datapath widths and the
// left-normalizer state type.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SRL = 2'b00,
    SHIFT_SRA = 2'b01,
    SHIFT_SLL = 2'b10
  } shift_op_t;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

endpackage

// File: rtl/shift_normalizer.sv
// Iterative left-normalizer: one left shift per cycle until the MSB is significant.
// Define SHIFT_NORM_SIGNED_EN to add the in_signed_i port and signed stop rule.
module shift_normalizer
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  localparam int SW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
`ifdef SHIFT_NORM_SIGNED_EN
  input  logic             in_signed_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [SW-1:0]    out_shamt_o,
  output logic             out_zero_o
);

  norm_state_t      state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [SW-1:0]    res_shamt_q, res_shamt_d;
  logic             res_zero_q, res_zero_d;
  logic             stop;
  logic             work_zero;

  // A nonzero operand always stops before its bits are shifted out, so an
  // all-zero work register in SHIFT can only mean a zero operand.
  assign work_zero = (work_q == '0);

`ifdef SHIFT_NORM_SIGNED_EN
  logic signed_q, signed_d;

  // Signed: stop once the top two bits differ; the count cap ends all-ones.
  assign stop = signed_q ? ((work_q[WIDTH-1] ^ work_q[WIDTH-2]) || (cnt_q == SW'(WIDTH-1)))
                         : work_q[WIDTH-1];
`else
  assign stop = work_q[WIDTH-1];
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_shamt_d = res_shamt_q;
    res_zero_d  = res_zero_q;
`ifdef SHIFT_NORM_SIGNED_EN
    signed_d    = signed_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          work_d  = in_data_i;
          cnt_d   = '0;
`ifdef SHIFT_NORM_SIGNED_EN
          signed_d = in_signed_i;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_zero) begin
          // Zero skips all iterations so its latency matches a shamt-0 operand.
          res_data_d  = '0;
          res_shamt_d = SW'(WIDTH);
          res_zero_d  = 1'b1;
          state_d     = DONE;
        end else if (stop) begin
          res_data_d  = work_q;
          res_shamt_d = cnt_q;
          res_zero_d  = 1'b0;
          state_d     = DONE;
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + SW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_shamt_q <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_shamt_q <= res_shamt_d;
      res_zero_q  <= res_zero_d;
    end
  end

`ifdef SHIFT_NORM_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) signed_q <= 1'b0;
    else        signed_q <= signed_d;
  end
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = res_data_q;
  assign out_shamt_o = res_shamt_q;
  assign out_zero_o  = res_zero_q;

endmodule
